// File: rtl/flash_boot_loader.sv
// -----------------------------------------------------------------------------
// flash_boot_loader
//
// Boot sequencer between the SPI configuration flash and the instruction
// memory. Holds the core in reset, issues one continuous SPI READ (0x03) at
// FLASH_BASE_ADDR, streams IMEM_DEPTH little-endian words into the IMEM write
// port, then releases the core.
//
// Ports
//   clk           core clock, all logic on posedge
//   reset_n       synchronous active-low reset
//   i_boot_skip   sampled in IDLE, 1 = skip the flash load
//   o_flash_sclk  SPI clock, mode 0, idles low
//   o_flash_cs_n  flash chip select, active low
//   o_flash_mosi  master out, MSB first
//   i_flash_miso  master in
//   imem_we       one-cycle IMEM write strobe
//   imem_addr     IMEM word index
//   imem_wdata    assembled 32-bit word
//   core_reset_n  low until the load is complete
//   busy          high while chip select is asserted
//   done          high once the sequence has finished, sticky until reset
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | one cycle after reset, decides between load and skip
// CS_SETUP | cs_n low, sclk low for SCLK_DIV cycles before the first bit
// CMD      | shifting out the 8-bit READ command
// ADDR     | shifting out the 24-bit flash base address
// DATA     | shifting in data words, one IMEM write per 32 bits
// CS_HOLD  | sclk low, cs_n still low for SCLK_DIV cycles
// DONE     | core released, flash pins idle until reset
// -----------------------------------------------------------------------------
module flash_boot_loader #(
    parameter int unsigned IMEM_DEPTH      = 128,
    parameter logic [23:0] FLASH_BASE_ADDR = 24'h300000,
    parameter int unsigned SCLK_DIV        = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_boot_skip,
    output logic                          o_flash_sclk,
    output logic                          o_flash_cs_n,
    output logic                          o_flash_mosi,
    input  logic                          i_flash_miso,
    output logic                          imem_we,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    output logic [31:0]                   imem_wdata,
    output logic                          core_reset_n,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned      AW         = $clog2(IMEM_DEPTH);
    localparam int unsigned      DIV_W      = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(SCLK_DIV - 1);
    localparam logic [AW-1:0]    LAST_ADDR  = AW'(IMEM_DEPTH - 1);
    localparam logic [7:0]       CMD_READ   = 8'h03;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        CMD,
        ADDR,
        DATA,
        CS_HOLD,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;         // phase timer, counts down to terminal count
    logic [4:0]       bit_q, bit_d;         // bits left in the current field, minus one
    logic             sclk_q, sclk_d;
    logic             cs_n_q, cs_n_d;
    logic             busy_q, busy_d;
    logic [31:0]      tx_q, tx_d;           // outgoing bits, tx_q[31] is the bit on the wire
    logic [31:0]      sr_q, sr_d;           // shadow: received bits in arrival order
    logic             word_done_q, word_done_d;
    logic             we_q, we_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             done_q, done_d;
    logic             div_tc;

    assign div_tc = (div_q == '0);

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        sclk_d      = sclk_q;
        cs_n_d      = cs_n_q;
        busy_d      = busy_q;
        tx_d        = tx_q;
        sr_d        = sr_q;
        word_done_d = 1'b0;
        we_d        = word_done_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        done_d      = done_q;

        // The first byte received lands in the top of the shadow, but it
        // belongs in the least significant byte of the IMEM word.
        if (word_done_q) begin
            wdata_d = {sr_q[7:0], sr_q[15:8], sr_q[23:16], sr_q[31:24]};
        end

        // Address holds at the last word instead of wrapping.
        if (we_q && (addr_q != LAST_ADDR)) begin
            addr_d = addr_q + AW'(1);
        end

        case (state_q)
            IDLE: begin
                if (i_boot_skip) begin
                    state_d = DONE;
                end else begin
                    state_d = CS_SETUP;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    tx_d    = {CMD_READ, FLASH_BASE_ADDR};
                    div_d   = DIV_RELOAD;
                end
            end

            CS_SETUP: begin
                if (div_tc) begin
                    state_d = CMD;
                    div_d   = DIV_RELOAD;
                    bit_d   = 5'd7;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end

            CMD, ADDR, DATA: begin
                if (!div_tc) begin
                    div_d = div_q - 1'b1;
                end else begin
                    div_d  = DIV_RELOAD;
                    sclk_d = ~sclk_q;
                    if (sclk_q) begin
                        // Falling edge: sample MISO and launch the next MOSI
                        // bit. Once the header is out tx_q is all zeros, so
                        // MOSI stays low through DATA.
                        tx_d  = {tx_q[30:0], 1'b0};
                        sr_d  = {sr_q[30:0], i_flash_miso};
                        bit_d = bit_q - 5'd1;
                        if (bit_q == 5'd0) begin
                            if (state_q == CMD) begin
                                state_d = ADDR;
                                bit_d   = 5'd23;
                            end else if (state_q == ADDR) begin
                                state_d = DATA;
                                bit_d   = 5'd31;
                            end else begin
                                word_done_d = 1'b1;
                                bit_d       = 5'd31;
                                if (addr_q == LAST_ADDR) begin
                                    state_d = CS_HOLD;
                                end
                            end
                        end
                    end
                end
            end

            CS_HOLD: begin
                if (div_tc) begin
                    state_d = DONE;
                    cs_n_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end

            DONE: begin
                done_d = 1'b1;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            tx_q        <= '0;
            sr_q        <= '0;
            word_done_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            sclk_q      <= sclk_d;
            cs_n_q      <= cs_n_d;
            busy_q      <= busy_d;
            tx_q        <= tx_d;
            sr_q        <= sr_d;
            word_done_q <= word_done_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            done_q      <= done_d;
        end
    end

    assign o_flash_sclk = sclk_q;
    assign o_flash_cs_n = cs_n_q;
    assign o_flash_mosi = tx_q[31];
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign core_reset_n = done_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_flash_boot_loader.sv
// Testbench for flash_boot_loader: default instance driven by a mode-0 flash
// model, plus a small SCLK_DIV=1 / IMEM_DEPTH=4 instance with MISO held high.
module tb_flash_boot_loader;

    localparam logic [23:0] BASE = 24'h300000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic skip;
    logic noise_en;
    logic noise_bit;

    // default instance
    logic        sclk_a, cs_n_a, mosi_a, we_a, crn_a, busy_a, done_a;
    logic [6:0]  addr_a;
    logic [31:0] wdata_a;
    logic        miso_a;

    // small instance
    logic        sclk_b, cs_n_b, mosi_b, we_b, crn_b, busy_b, done_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;

    logic fl_miso = 1'b0;
    assign miso_a = noise_en ? noise_bit : fl_miso;

    flash_boot_loader dut_a (
        .clk(clk), .reset_n(reset_n), .i_boot_skip(skip),
        .o_flash_sclk(sclk_a), .o_flash_cs_n(cs_n_a), .o_flash_mosi(mosi_a),
        .i_flash_miso(miso_a), .imem_we(we_a), .imem_addr(addr_a),
        .imem_wdata(wdata_a), .core_reset_n(crn_a), .busy(busy_a), .done(done_a)
    );

    flash_boot_loader #(.IMEM_DEPTH(4), .FLASH_BASE_ADDR(BASE), .SCLK_DIV(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .i_boot_skip(skip),
        .o_flash_sclk(sclk_b), .o_flash_cs_n(cs_n_b), .o_flash_mosi(mosi_b),
        .i_flash_miso(1'b1), .imem_we(we_b), .imem_addr(addr_b),
        .imem_wdata(wdata_b), .core_reset_n(crn_b), .busy(busy_b), .done(done_b)
    );

    // ---------------- flash contents and mode-0 flash model ----------------
    logic [7:0] flash_mem [0:511];

    function automatic logic flash_bit(input logic [23:0] a, input int k);
        int off;
        logic [7:0] by;
        off = int'(a) - int'(BASE) + k / 8;
        if (off < 0 || off >= 512) return 1'b0;
        by = flash_mem[off];
        return by[7 - (k % 8)];
    endfunction

    function automatic logic [31:0] word_a(input int w);
        return {flash_mem[4*w+3], flash_mem[4*w+2], flash_mem[4*w+1], flash_mem[4*w]};
    endfunction

    logic        fl_sclk_prev = 1'b0;
    int          fl_rise = 0;
    int          fl_bit = 0;
    int          fl_hdr_cnt = 0;
    logic [31:0] fl_hdr = '0;

    always @(sclk_a or cs_n_a) begin
        if (cs_n_a !== 1'b0) begin
            fl_rise = 0;
            fl_bit  = 0;
            fl_miso = 1'b0;
        end else if (sclk_a && !fl_sclk_prev) begin
            if (fl_rise < 32) begin
                fl_hdr = {fl_hdr[30:0], mosi_a};
                if (fl_rise == 31) fl_hdr_cnt++;
            end
            fl_rise++;
        end else if (!sclk_a && fl_sclk_prev && fl_rise >= 32) begin
            fl_miso = flash_bit(fl_hdr[23:0], fl_bit);
            fl_bit++;
        end
        fl_sclk_prev = sclk_a;
    end

    // ---------------- behavioural timing model ----------------
    // n = number of posedges since the last edge that saw reset_n low.
    typedef struct {
        logic sclk, cs_n, mosi, we, busy, crn, done;
        int   addr;
        int   cw;     // words written so far
    } exp_t;

    function automatic exp_t model(input int nn, input bit skp, input int sd, input int dep);
        exp_t e;
        int tb, nbits, t, ncs, b, first_we;
        logic [31:0] hdr;
        hdr = {8'h03, BASE};
        e.sclk = 0; e.cs_n = 1; e.mosi = 0; e.we = 0; e.busy = 0;
        e.crn = 0; e.done = 0; e.addr = 0; e.cw = 0;
        if (nn <= 0) return e;
        if (skp) begin
            if (nn >= 2) begin e.crn = 1; e.done = 1; end
            return e;
        end
        tb    = 2 * sd;
        nbits = 32 + 32 * dep;
        t     = nn - sd - 1;               // 0 at the start of the first bit cell
        ncs   = 2 * sd + 1 + nbits * tb;   // edge on which cs_n returns high
        if (nn < ncs) begin e.cs_n = 0; e.busy = 1; end
        if (nn > ncs) begin e.crn = 1; e.done = 1; end
        if (t >= 0 && t < nbits * tb && (t % tb) >= sd) e.sclk = 1;
        b = (t < 0) ? 0 : t / tb;
        if (nn < ncs && b < 32) e.mosi = hdr[31 - b];
        first_we = 64 * tb + 1;
        if (t >= first_we) begin
            e.cw = (t - first_we) / (32 * tb) + 1;
            if (e.cw > dep) e.cw = dep;
            e.we = (t == first_we + (e.cw - 1) * 32 * tb);
        end
        e.addr = e.we ? e.cw - 1 : e.cw;
        if (e.addr > dep - 1) e.addr = dep - 1;
        return e;
    endfunction

    // ---------------- checking ----------------
    int checks = 0;
    int failures = 0;
    int n = 0;
    bit skip_lat = 0;
    int hdr_seen = 0;
    int wr_cnt_a = 0;
    int first_addr = -1;
    logic [31:0] cap_a [0:127];
    int b_cs_low = 0;
    int b_wr = 0;
    bit b_first_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s n=%0d actual=%h required=%h", name, n, act, exp);
        end
    endtask

    task automatic step();
        exp_t ea, eb;
        @(posedge clk);
        if (!reset_n) n = 0;
        else begin
            n++;
            if (n == 1) skip_lat = skip;
        end
        @(negedge clk);
        ea = model(n, skip_lat, 2, 128);
        chk("a_sclk", 32'(sclk_a), 32'(ea.sclk));
        chk("a_cs_n", 32'(cs_n_a), 32'(ea.cs_n));
        chk("a_mosi", 32'(mosi_a), 32'(ea.mosi));
        chk("a_we", 32'(we_a), 32'(ea.we));
        chk("a_addr", 32'(addr_a), 32'(ea.addr));
        chk("a_wdata", wdata_a, (ea.cw == 0) ? 32'h0 : word_a(ea.cw - 1));
        chk("a_busy", 32'(busy_a), 32'(ea.busy));
        chk("a_core_reset_n", 32'(crn_a), 32'(ea.crn));
        chk("a_done", 32'(done_a), 32'(ea.done));
        if (we_a === 1'b1) begin
            if (wr_cnt_a == 0) first_addr = int'(addr_a);
            cap_a[addr_a] = wdata_a;
            wr_cnt_a++;
        end
        if (fl_hdr_cnt != hdr_seen) begin
            hdr_seen = fl_hdr_cnt;
            chk("flash_header", fl_hdr, {8'h03, BASE});
        end

        eb = model(n, skip_lat, 1, 4);
        chk("b_sclk", 32'(sclk_b), 32'(eb.sclk));
        chk("b_cs_n", 32'(cs_n_b), 32'(eb.cs_n));
        chk("b_mosi", 32'(mosi_b), 32'(eb.mosi));
        chk("b_we", 32'(we_b), 32'(eb.we));
        chk("b_addr", 32'(addr_b), 32'(eb.addr));
        chk("b_wdata", wdata_b, (eb.cw == 0) ? 32'h0 : 32'hFFFF_FFFF);
        chk("b_busy", 32'(busy_b), 32'(eb.busy));
        chk("b_core_reset_n", 32'(crn_b), 32'(eb.crn));
        chk("b_done", 32'(done_b), 32'(eb.done));
        if (!b_first_done) begin
            if (cs_n_b === 1'b0) b_cs_low++;
            if (we_b === 1'b1) b_wr++;
            if (done_b === 1'b1) b_first_done = 1;
        end
    endtask

    initial begin
        int cyc;
        int wr_before;
        int cs_low;
        int done_n;
        int hdr_before;
        logic [31:0] wv;

        reset_n   = 1'b0;
        skip      = 1'b0;
        noise_en  = 1'b0;
        noise_bit = 1'b0;
        for (int w = 0; w < 128; w++) begin
            wv = (w == 0) ? 32'h4433_2211 : (32'hA500_0000 | 32'(w));
            for (int i = 0; i < 4; i++) flash_mem[4*w+i] = wv[8*i +: 8];
        end
        for (int w = 0; w < 128; w++) cap_a[w] = '0;

        // reset values
        repeat (3) step();
        chk("rst_cs_n", 32'(cs_n_a), 32'd1);
        chk("rst_sclk", 32'(sclk_a), 32'd0);
        chk("rst_core_reset_n", 32'(crn_a), 32'd0);
        chk("rst_imem_we", 32'(we_a), 32'd0);

        // full load at defaults
        reset_n = 1'b1;
        cyc = 0;
        while (crn_a !== 1'b1 && cyc < 20000) begin step(); cyc++; end
        chk("load_core_reset_n", 32'(crn_a), 32'd1);
        chk("load_cycles", 32'(n), 32'd16518);
        chk("load_done", 32'(done_a), 32'd1);
        chk("load_writes", 32'(wr_cnt_a), 32'd128);
        chk("word0_byte_order", cap_a[0], 32'h4433_2211);
        chk("word64", cap_a[64], 32'hA500_0040);
        chk("word127", cap_a[127], 32'hA500_007F);
        chk("header_count", 32'(hdr_seen), 32'd1);
        chk("b_cs_low_cycles", 32'(b_cs_low), 32'd322);
        chk("b_writes", 32'(b_wr), 32'd4);

        // MISO noise after done
        wr_before = wr_cnt_a;
        noise_en  = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            noise_bit = 1'($urandom_range(0, 1));
            step();
        end
        noise_en = 1'b0;
        chk("noise_no_writes", 32'(wr_cnt_a), 32'(wr_before));
        chk("noise_cs_n", 32'(cs_n_a), 32'd1);

        // boot skip
        reset_n = 1'b0;
        skip    = 1'b1;
        repeat (2) step();
        reset_n   = 1'b1;
        wr_before = wr_cnt_a;
        cs_low    = 0;
        done_n    = -1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (cs_n_a !== 1'b1) cs_low++;
            if (done_a === 1'b1 && done_n < 0) done_n = n;
        end
        skip = 1'b0;
        chk("skip_done_cycle", 32'(done_n), 32'd2);
        chk("skip_cs_activity", 32'(cs_low), 32'd0);
        chk("skip_no_writes", 32'(wr_cnt_a), 32'(wr_before));

        // reset in the middle of word 37
        reset_n = 1'b0;
        step();
        reset_n  = 1'b1;
        wr_cnt_a = 0;
        cyc = 0;
        while (wr_cnt_a < 37 && cyc < 6000) begin step(); cyc++; end
        chk("mid_writes_reached", 32'(wr_cnt_a), 32'd37);
        repeat (100) step();
        reset_n = 1'b0;
        step();
        chk("midrst_cs_n", 32'(cs_n_a), 32'd1);
        chk("midrst_core_reset_n", 32'(crn_a), 32'd0);
        chk("midrst_we", 32'(we_a), 32'd0);
        reset_n    = 1'b1;
        hdr_before = hdr_seen;
        wr_cnt_a   = 0;
        first_addr = -1;
        cyc = 0;
        while (crn_a !== 1'b1 && cyc < 20000) begin step(); cyc++; end
        chk("restart_header_reissued", 32'(hdr_seen), 32'(hdr_before + 1));
        chk("restart_first_addr", 32'(first_addr), 32'd0);
        chk("restart_writes", 32'(wr_cnt_a), 32'd128);
        chk("restart_cycles", 32'(n), 32'd16518);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
